fifo_drain_ctrl: RTL and testbench

Read-side controller for the FIFO memory block. It watches the FIFO's `fifo_empty`, `almost_empty` and `error` flags and issues `fifo_rd` pops. It captures each popped word one cycle later and delivers it downstream over a valid/ready handshake through a 2-entry output buffer. It is the consumer counterpart to the FIFO write path and never pops more words than the buffer can hold.

---
 rtl/fifo_drain_pkg.sv | 19 +
 rtl/fifo_drain_ctrl_skid.sv | 63 ++++++
 rtl/fifo_drain_ctrl.sv | 110 +++++++++++
 tb/tb_fifo_drain_ctrl.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: shared definitions for the FIFO read-side drain controller.
//   state_t         : drain FSM encoding (IDLE=0, DRAIN=1)
//   OUT_DEPTH       : depth of the downstream output buffer
//   DEF_WORD_SIZE   : default data word width
//   DEF_PTR_L       : default width of occupancy-related signals
//   DEF_CNT_W       : default width of the popped-word counter
package fifo_drain_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam int OUT_DEPTH     = 2;
  localparam int DEF_WORD_SIZE = 6;
  localparam int DEF_PTR_L     = 3;
  localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/fifo_drain_ctrl_skid.sv
// fifo_out_skid: 2-entry FIFO-ordered output buffer with a valid/ready head.
// Ports:
//   clk, reset_L        : clock, synchronous active-low reset
//   push, push_data     : write one word into the tail (caller guarantees room)
//   ready_in            : downstream accepts the head this cycle
//   data_out, valid_out : head of the buffer (data_out reads 0 when empty)
//   buf_count           : number of words currently held (0..2)
module fifo_out_skid
  import fifo_drain_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 push,
  input  logic [WORD_SIZE-1:0] push_data,
  input  logic                 ready_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic [1:0]           buf_count
);

  // mem[0] is always the head; a read shifts mem[1] forward.
  logic [WORD_SIZE-1:0] mem [OUT_DEPTH];
  logic [1:0]           count;
  logic                 take;

  assign valid_out = (count != 2'd0);
  assign take      = valid_out & ready_in;
  assign data_out  = valid_out ? mem[0] : '0;
  assign buf_count = count;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      count <= 2'd0;
    end else begin
      case ({push, take})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an empty buffer masks data_out to zero.
  // When push and take coincide the later assignment to mem[0] wins,
  // which places the new word directly at the head of a 1-entry buffer.
  always_ff @(posedge clk) begin
    if (take) begin
      mem[0] <= mem[1];
    end
    if (push) begin
      if (take) begin
        if (count == 2'd2) mem[1] <= push_data;
        else               mem[0] <= push_data;
      end else begin
        if (count == 2'd0) mem[0] <= push_data;
        else               mem[1] <= push_data;
      end
    end
  end

endmodule

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: read-side controller for the FIFO memory block.
// Watches the FIFO flags, issues fifo_rd pops, captures each popped word one
// cycle later and hands it downstream through a 2-entry valid/ready buffer.
// Ports:
//   clk, reset_L          : clock, synchronous active-low reset
//   rd_en                 : drain enable (in-flight word still completes)
//   flush                 : force draining to empty (burst mode only)
//   fifo_empty            : FIFO empty flag
//   almost_empty          : FIFO occupancy <= its empty threshold
//   fifo_error            : FIFO error flag
//   fifo_data             : FIFO read data, valid the cycle after fifo_rd
//   fifo_rd               : pop request
//   data_out, valid_out   : head of the output buffer
//   ready_in              : downstream accepts data_out
//   pop_count             : words popped since reset, wrapping
//   drain_err             : sticky protocol error (error flag after a pop)
//   busy                  : FSM is in DRAIN
// Build option: define FIFO_DRAIN_BURST_EN to start draining only when the
// FIFO is above its empty threshold (or on flush); otherwise draining starts
// as soon as the FIFO is non-empty and flush is ignored.
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int PTR_L     = DEF_PTR_L,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 rd_en,
  input  logic                 flush,
  input  logic                 fifo_empty,
  input  logic                 almost_empty,
  input  logic                 fifo_error,
  input  logic [WORD_SIZE-1:0] fifo_data,
  output logic                 fifo_rd,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [CNT_W-1:0]     pop_count,
  output logic                 drain_err,
  output logic                 busy
);

  state_t           state;
  state_t           state_nx;
  logic             inflight;
  logic [1:0]       buf_count;
  logic [PTR_L-1:0] occ;
  logic             free;
  logic             start;

`ifdef FIFO_DRAIN_BURST_EN
  assign start = ~almost_empty | flush;
`else
  logic unused_burst_inputs;
  assign unused_burst_inputs = flush ^ almost_empty;
  assign start = ~fifo_empty;
`endif

  // Words committed to the output path: buffered plus the one in flight.
  assign occ = PTR_L'(buf_count) + PTR_L'(inflight);

  // A head leaving this cycle makes room for the next pop, which lands two
  // cycles later; this keeps the path at one word per cycle under ready_in.
  assign free = (occ < PTR_L'(OUT_DEPTH)) | (valid_out & ready_in);

  // Gated by reset_L so that no pop escapes during the reset cycle.
  assign fifo_rd = reset_L & (state == DRAIN) & rd_en & ~fifo_empty & free;
  assign busy    = (state == DRAIN);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (rd_en & start) state_nx = DRAIN;
      DRAIN: if (fifo_empty & ~inflight) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stage boundary: pop issued -> word captured from fifo_data next cycle.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state     <= IDLE;
      inflight  <= 1'b0;
      pop_count <= '0;
      drain_err <= 1'b0;
    end else begin
      state    <= state_nx;
      inflight <= fifo_rd;
      if (inflight) pop_count <= pop_count + 1'b1;
      if (inflight & fifo_error) drain_err <= 1'b1;
    end
  end

  // Stage boundary: captured word -> output buffer tail.
  fifo_out_skid #(
    .WORD_SIZE (WORD_SIZE)
  ) u_skid (
    .clk       (clk),
    .reset_L   (reset_L),
    .push      (inflight),
    .push_data (fifo_data),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .buf_count (buf_count)
  );

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
module tb_fifo_drain_ctrl;

  localparam int W   = 6;
  localparam int CW  = 8;
  localparam int THR = 2;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          rd_en;
  logic          flush;
  logic          fifo_empty;
  logic          almost_empty;
  logic          fifo_error;
  logic [W-1:0]  fifo_data;
  logic          fifo_rd;
  logic [W-1:0]  data_out;
  logic          valid_out;
  logic          ready_in;
  logic [CW-1:0] pop_count;
  logic          drain_err;
  logic          busy;

  always #5 clk = ~clk;

  fifo_drain_ctrl #(.WORD_SIZE(W), .PTR_L(3), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .rd_en        (rd_en),
    .flush        (flush),
    .fifo_empty   (fifo_empty),
    .almost_empty (almost_empty),
    .fifo_error   (fifo_error),
    .fifo_data    (fifo_data),
    .fifo_rd      (fifo_rd),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .pop_count    (pop_count),
    .drain_err    (drain_err),
    .busy         (busy)
  );

  int checks = 0;
  int errors = 0;

  // Environment / reference model:
  //   q      : contents of the upstream FIFO
  //   sb     : every word written, in order, not yet delivered downstream
  //   pulses : pops issued; delivered : handshakes seen; landed : pops whose
  //            capture cycle has completed (what pop_count must equal)
  logic [W-1:0] q[$];
  logic [W-1:0] sb[$];
  int   pulses, delivered, landed, cyc;
  logic prev_rd, rd_now, acc_now;

  task automatic update_flags();
    fifo_empty   = (q.size() == 0);
    almost_empty = (q.size() <= THR);
  endtask

  task automatic push_word(input logic [W-1:0] w);
    q.push_back(w);
    sb.push_back(w);
    update_flags();
  endtask

  task automatic clear_model();
    q.delete();
    sb.delete();
    pulses = 0; delivered = 0; landed = 0; prev_rd = 1'b0;
    update_flags();
  endtask

  // One clock cycle: sample at the falling edge, then let the FIFO model
  // react to a pop just after the rising edge.
  task automatic tick();
    logic [W-1:0] exp_w;
    #4;
    rd_now  = fifo_rd;
    acc_now = valid_out & ready_in;
    if (acc_now) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL deliver_extra: got %0h, required no delivery", data_out);
      end else begin
        exp_w = sb.pop_front();
        if (data_out !== exp_w) begin
          errors++;
          $display("FAIL deliver_order: got %0h, required %0h", data_out, exp_w);
        end
      end
      delivered++;
    end
    checks++;
    if (pulses + int'(rd_now) - delivered > 2) begin
      errors++;
      $display("FAIL hold_bound: words held %0d, required <= 2", pulses + int'(rd_now) - delivered);
    end
    @(posedge clk);
    #1;
    if (prev_rd) landed++;
    prev_rd = rd_now;
    if (rd_now) begin
      pulses++;
      if (q.size() == 0) begin
        errors++; checks++;
        $display("FAIL pop_empty: fifo_rd %0d with empty FIFO, required 0", rd_now);
      end else begin
        fifo_data = q.pop_front();
      end
    end
    update_flags();
    cyc++;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    tick();
    clear_model();
    reset_L = 1'b1;
  endtask

  task automatic drain_all(input int budget);
    rd_en = 1'b1; ready_in = 1'b1; flush = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0 && q.size() == 0 && !busy) break;
      tick();
    end
    flush = 1'b0;
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_done: pending %0d busy %0d, required 0 and 0", sb.size(), busy);
    end
    checks++;
    if (pop_count !== CW'(landed)) begin
      errors++;
      $display("FAIL pop_count: got %0d, required %0d", pop_count, CW'(landed));
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({fifo_rd, valid_out, busy, drain_err} !== 4'b0000 || data_out !== '0 || pop_count !== '0) begin
      errors++;
      $display("FAIL reset_values: rd %0d v %0d busy %0d err %0d d %0h cnt %0d, required all 0",
               fifo_rd, valid_out, busy, drain_err, data_out, pop_count);
    end
  endtask

  task automatic test_basic();
    int rdc[$];
    int vc[$];
    rd_en = 1'b1; ready_in = 1'b1;
    push_word(6'h0A); push_word(6'h15); push_word(6'h2F);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rd_now)  rdc.push_back(cyc - 1);
      if (acc_now) vc.push_back(cyc - 1);
    end
    checks++;
    if (rdc.size() != 3 || vc.size() != 3) begin
      errors++;
      $display("FAIL basic_counts: pops %0d delivered %0d, required 3 and 3", rdc.size(), vc.size());
    end else begin
      checks++;
      if (rdc[2] - rdc[0] != 2) begin
        errors++;
        $display("FAIL basic_pop_spacing: span %0d, required 2", rdc[2] - rdc[0]);
      end
      checks++;
      if (vc[0] - rdc[0] != 2) begin
        errors++;
        $display("FAIL basic_latency: got %0d cycles, required 2", vc[0] - rdc[0]);
      end
      checks++;
      if (vc[2] - vc[0] != 2) begin
        errors++;
        $display("FAIL basic_throughput: span %0d, required 2", vc[2] - vc[0]);
      end
    end
    checks++;
    if (pop_count !== 8'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: cnt %0d busy %0d, required 3 and 0", pop_count, busy);
    end
  endtask

  task automatic test_backpressure();
    int p0;
    logic [W-1:0] w[4];
    p0 = pulses;
    rd_en = 1'b1; ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w[i] = W'($urandom);
      push_word(w[i]);
    end
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (pulses - p0 != 2) begin
      errors++;
      $display("FAIL bp_pops: got %0d, required 2", pulses - p0);
    end
    checks++;
    if (valid_out !== 1'b1 || data_out !== w[0]) begin
      errors++;
      $display("FAIL bp_head: v %0d d %0h, required 1 and %0h", valid_out, data_out, w[0]);
    end
    drain_all(30);
    checks++;
    if (pulses - p0 != 4) begin
      errors++;
      $display("FAIL bp_total: got %0d, required 4", pulses - p0);
    end
  endtask

  task automatic test_start_mode();
    int p0;
    rd_en = 1'b1; ready_in = 1'b1; flush = 1'b0;
`ifdef FIFO_DRAIN_BURST_EN
    p0 = pulses;
    push_word(W'($urandom)); push_word(W'($urandom));
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (pulses - p0 != 0) begin
      errors++;
      $display("FAIL burst_hold: pops %0d, required 0", pulses - p0);
    end
    push_word(W'($urandom));
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (pulses - p0 != 3 || sb.size() != 0) begin
      errors++;
      $display("FAIL burst_drain: pops %0d pending %0d, required 3 and 0", pulses - p0, sb.size());
    end
    p0 = pulses;
    flush = 1'b1;
    push_word(W'($urandom));
    for (int i = 0; i < 8; i++) tick();
    flush = 1'b0;
    checks++;
    if (pulses - p0 != 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL burst_flush: pops %0d pending %0d, required 1 and 0", pulses - p0, sb.size());
    end
`else
    p0 = pulses;
    push_word(W'($urandom));
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (pulses - p0 != 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL single_word: pops %0d pending %0d, required 1 and 0", pulses - p0, sb.size());
    end
    p0 = pulses;
    flush = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    flush = 1'b0;
    checks++;
    if (pulses - p0 != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_ignored: pops %0d busy %0d, required 0 and 0", pulses - p0, busy);
    end
`endif
  endtask

  task automatic test_rd_en_drop();
    int p0;
    int d0;
    rd_en = 1'b1; ready_in = 1'b1;
    for (int i = 0; i < 5; i++) push_word(W'($urandom));
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rd_now) break;
    end
    rd_en = 1'b0;
    #1;
    checks++;
    if (fifo_rd !== 1'b0) begin
      errors++;
      $display("FAIL rd_en_drop: fifo_rd %0d, required 0", fifo_rd);
    end
    p0 = pulses; d0 = delivered;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (pulses != p0 || delivered != pulses) begin
      errors++;
      $display("FAIL rd_en_inflight: extra pops %0d undelivered %0d, required 0 and 0",
               pulses - p0, pulses - delivered);
    end
    checks++;
    if (delivered == d0) begin
      errors++;
      $display("FAIL rd_en_landed: delivered %0d after drop, required >= 1", delivered - d0);
    end
    drain_all(30);
  endtask

  task automatic test_error();
    do_reset();
    rd_en = 1'b0; fifo_error = 1'b1;
    for (int i = 0; i < 2; i++) tick();
    fifo_error = 1'b0;
    checks++;
    if (drain_err !== 1'b0) begin
      errors++;
      $display("FAIL err_no_pop: drain_err %0d, required 0", drain_err);
    end
    rd_en = 1'b1; ready_in = 1'b1; flush = 1'b1;
    push_word(W'($urandom));
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rd_now) break;
    end
    fifo_error = 1'b1;
    tick();
    fifo_error = 1'b0; rd_en = 1'b0; flush = 1'b0;
    checks++;
    if (drain_err !== 1'b1) begin
      errors++;
      $display("FAIL err_set: drain_err %0d, required 1", drain_err);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (drain_err !== 1'b1) begin
        errors++;
        $display("FAIL err_sticky: drain_err %0d at idle cycle %0d, required 1", drain_err, i);
      end
    end
    do_reset();
    checks++;
    if (drain_err !== 1'b0) begin
      errors++;
      $display("FAIL err_reset: drain_err %0d, required 0", drain_err);
    end
  endtask

  task automatic test_reset_mid();
    rd_en = 1'b1; ready_in = 1'b1;
    for (int i = 0; i < 4; i++) push_word(W'($urandom));
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rd_now) break;
    end
    reset_L = 1'b0;
    tick();
    checks++;
    if (rd_now !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_rd: fifo_rd %0d in reset cycle, required 0", rd_now);
    end
    clear_model();
    checks++;
    if (valid_out !== 1'b0 || pop_count !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_state: v %0d cnt %0d busy %0d, required 0 0 0", valid_out, pop_count, busy);
    end
    reset_L = 1'b1;
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (q.size() < 8 && ($urandom % 3) != 0) push_word(W'($urandom));
      ready_in = (($urandom % 4) != 0);
      rd_en    = (($urandom % 8) != 0);
      flush    = (($urandom % 16) == 0);
      tick();
    end
    drain_all(100);
  endtask

  task automatic test_wrap();
    logic seen255;
    do_reset();
    seen255 = 1'b0;
    for (int i = 0; i < 256; i++) push_word(W'($urandom));
    rd_en = 1'b1; ready_in = 1'b1; flush = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (landed >= 256 && !busy) break;
      tick();
      if (landed == 255 && !seen255) begin
        seen255 = 1'b1;
        checks++;
        if (pop_count !== 8'd255) begin
          errors++;
          $display("FAIL wrap_255: got %0d, required 255", pop_count);
        end
      end
    end
    flush = 1'b0;
    checks++;
    if (landed != 256 || pop_count !== 8'd0) begin
      errors++;
      $display("FAIL wrap_zero: landed %0d cnt %0d, required 256 and 0", landed, pop_count);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL wrap_delivered: pending %0d, required 0", sb.size());
    end
  endtask

  initial begin
    reset_L = 1'b0; rd_en = 1'b0; flush = 1'b0; fifo_error = 1'b0;
    ready_in = 1'b0; fifo_data = '0; cyc = 0;
    clear_model();
    test_reset();
    test_basic();
    test_backpressure();
    test_start_mode();
    test_rd_en_drop();
    test_error();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
